// File: rtl/ram128x1s_reader.sv
// Readback engine for a 128x1 distributed RAM.
// The engine steps the RAM address once per cycle and samples the
// asynchronous RAM output. It packs the bits LSB-first into WORD_W-bit
// words and sends them out on a valid/ready stream.
module ram128x1s_reader #(
  parameter int unsigned WORD_W = 8
) (
  input  logic              CLK,
  input  logic              RSTN,
  input  logic              START,
  input  logic              ABORT,
  output logic [6:0]        A,
  input  logic              RAM_O,
  output logic [WORD_W-1:0] M_DATA,
  output logic              M_VALID,
  input  logic              M_READY,
  output logic              BUSY,
  output logic              DONE
);

  localparam int unsigned NWORDS = 128 / WORD_W;
  localparam int unsigned CNT_W  = (WORD_W > 1) ? $clog2(WORD_W) : 1;
  localparam logic [CNT_W-1:0] LAST_BIT = CNT_W'(WORD_W - 1);

  // A sweep always covers the whole RAM, so the word width must tile 128 bits.
  if (NWORDS * WORD_W != 128) begin : g_bad_word_w
    $error("ram128x1s_reader: WORD_W must divide 128");
  end

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SCAN  = 2'd1,
    DRAIN = 2'd2
  } state_t;

  state_t            state;
  logic [CNT_W-1:0]  bitcnt;
  logic [WORD_W-1:0] shreg;
  logic [WORD_W-1:0] word_next;
  logic              complete;
  logic              stall;
  logic              accept;

  // Partial word with the current RAM bit merged in at position bitcnt.
  always_comb begin
    word_next         = shreg;
    word_next[bitcnt] = RAM_O;
  end

  // Handshake qualifiers. A completing edge with an unaccepted word pending stalls.
  always_comb begin
    complete = (bitcnt == LAST_BIT);
    accept   = M_VALID & M_READY;
    stall    = M_VALID & ~M_READY & complete;
  end

  // Sweep FSM, address generator, word assembler and output stream registers.
  always_ff @(posedge CLK or negedge RSTN) begin
    if (!RSTN) begin
      state   <= IDLE;
      A       <= '0;
      bitcnt  <= '0;
      shreg   <= '0;
      M_DATA  <= '0;
      M_VALID <= 1'b0;
      BUSY    <= 1'b0;
      DONE    <= 1'b0;
    end else begin
      DONE <= 1'b0;
      if (ABORT && (state != IDLE)) begin
        state   <= IDLE;
        A       <= '0;
        bitcnt  <= '0;
        M_VALID <= 1'b0;
        BUSY    <= 1'b0;
      end else begin
        unique case (state)
          IDLE: begin
            if (START) begin
              state  <= SCAN;
              A      <= '0;
              bitcnt <= '0;
              BUSY   <= 1'b1;
            end
          end
          SCAN: begin
            if (!stall) begin
              shreg <= word_next;
              A     <= A + 7'd1;
              if (complete) begin
                // Load the new word even if the old one is being accepted at
                // this edge, so back-to-back words flow without a bubble.
                M_DATA  <= word_next;
                M_VALID <= 1'b1;
                bitcnt  <= '0;
                if (A == 7'd127) begin
                  state <= DRAIN;
                end
              end else begin
                bitcnt <= bitcnt + CNT_W'(1);
                if (accept) begin
                  M_VALID <= 1'b0;
                end
              end
            end
          end
          DRAIN: begin
            if (accept) begin
              M_VALID <= 1'b0;
              DONE    <= 1'b1;
              BUSY    <= 1'b0;
              state   <= IDLE;
            end
          end
          default: begin
            state <= IDLE;
          end
        endcase
      end
    end
  end

endmodule
